ahb_to_apb_bridge: RTL and testbench
====================================

AHB_TO_APB_BRIDGE -- requirements
Module: ahb_to_apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of both buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of both buses.
REQ-003 SHALL have port HCLK, input, 1, the single clock for both sides (PCLK = HCLK).
REQ-004 SHALL have port HRESETn, input, 1; reset HRESETn, asynchronous, active-high; clock HCLK.
REQ-005 SHALL have port HSEL, input, 1, bridge select.
REQ-006 SHALL have port HADDR, input, ADDR_WIDTH, AHB address.
REQ-007 SHALL have port HTRANS, input, 2, AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 SHALL have port HWRITE, input, 1, 1 = write.
REQ-009 SHALL have port HWDATA, input, DATA_WIDTH, write data, valid in the data phase.
REQ-010 SHALL have port HRDATA, output, DATA_WIDTH, read data.
REQ-011 SHALL have port HRESP, output, 1, constant 0 (OKAY).
REQ-012 SHALL have port HREADY_OUT, output, 1, 0 = data phase extended.
REQ-013 SHALL have port PRDATA, input, DATA_WIDTH, APB read data from a zero-wait slave (no PREADY).
REQ-014 SHALL have ports PSEL, PENABLE, PWRITE (output, 1 each), PADDR (output, ADDR_WIDTH) and PWDATA (output, DATA_WIDTH), all registered APB outputs.

Function
REQ-015 SHALL accept a transfer at a rising HCLK edge only when HSEL=1, HTRANS[1]=1 and HREADY_OUT=1.
REQ-016 SHALL ignore IDLE/BUSY transfers, HSEL=0, and any address presented while HREADY_OUT=0; the master holds that address until HREADY_OUT=1.
REQ-017 SHALL latch HADDR into PADDR and HWRITE into PWRITE at acceptance.
REQ-018 SHALL use the FSM states IDLE, WWAIT, SETUP and ACCESS.
REQ-019 SHALL transition IDLE->WWAIT on accepting a write and IDLE->SETUP on accepting a read.
REQ-020 SHALL transition WWAIT->SETUP unconditionally, SETUP->ACCESS unconditionally and ACCESS->IDLE unconditionally.
REQ-021 SHALL, in WWAIT, sample HWDATA into PWDATA at the end of the cycle.
REQ-022 SHALL drive PSEL=1, PENABLE=0 in SETUP.
REQ-023 SHALL drive PSEL=1, PENABLE=1 in ACCESS.
REQ-024 SHALL drive PSEL=0, PENABLE=0 in IDLE and WWAIT.
REQ-025 SHALL hold PADDR, PWRITE and PWDATA stable from SETUP through ACCESS.
REQ-026 SHALL, for reads, capture PRDATA into HRDATA at the end of ACCESS and hold it until the next read completes.
REQ-027 SHALL drive HREADY_OUT=1 in IDLE and 0 in WWAIT, SETUP and ACCESS.
REQ-028 SHALL complete a read data phase in 3 cycles (2 wait states) and a write data phase in 4 cycles (3 wait states).
REQ-029 SHALL let the cycle after ACCESS (IDLE, HREADY_OUT=1) both complete the previous data phase and accept a pipelined next address, so back-to-back W/W, R/R, W/R and R/W sequences work.
REQ-030 SHALL keep HRESP=0 in every cycle.

Reset
REQ-031 SHALL, while reset is asserted, force state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, HRDATA=0 and HREADY_OUT=1.
REQ-032 SHALL, on reset asserted mid-transfer, abort the transfer immediately with no APB completion and drop PSEL/PENABLE asynchronously.

Configuration
REQ-033 SHALL, with macro AHB_APB_BRIDGE_SVA_EN defined, compile in concurrent assertions.
REQ-034 SHALL make those assertions check: PENABLE rises only one cycle after PSEL rose with PENABLE=0; PADDR/PWRITE/PWDATA stable while PSEL=1; PENABLE lasts exactly one cycle; HRESP==0; no PSEL without a prior accepted transfer.
REQ-035 SHALL compile no assertion logic without AHB_APB_BRIDGE_SVA_EN, with identical functional behaviour.

Structure
REQ-036 SHALL place in package ahb_apb_pkg: the htrans_t enum (IDLE/BUSY/NONSEQ/SEQ), the FSM state enum bridge_state_t, and the constants HRESP_OKAY=0 and HRESP_ERROR=1.
REQ-037 SHALL be a single module with no sub-modules.
REQ-038 SHALL treat the bundles ahb_interface and apb_interface as port groupings only, containing no logic.

Verification
REQ-039 SHALL verify write 0x04=0xBEEF_BEEF then read 0x04 -> one SETUP + one ACCESS per transfer, PWDATA=0xBEEF_BEEF, HRDATA=0xBEEF_BEEF when HREADY_OUT returns 1.
REQ-040 SHALL verify sequential writes to 0x20..0x2C of 0x1000_0000+i, then reads -> each read returns the matching value.
REQ-041 SHALL verify HSEL=0, HTRANS=00, HWRITE=1, HADDR=0x40 for 2 cycles -> PSEL=0, PENABLE=0 throughout.
REQ-042 SHALL verify pipelined write 0x10=0x1234 then 0x14=0x4321 with the second address held during wait states -> two APB writes in order, HREADY_OUT low 3 cycles each.
REQ-043 SHALL verify pipelined write 0x18=0x1234_5678 followed by read 0x18 -> read returns 0x1234_5678.
REQ-044 SHALL verify pipelined read 0x04 then write 0x1C=0xC0FF_EE00, and reset asserted during ACCESS -> correct ordering; on reset all outputs at reset values immediately.

Source files
------------

// File: rtl/ahb_to_apb_bridge_pkg.sv
// rtl/ahb_to_apb_bridge_pkg.sv - shared types and constants for the AHB to APB bridge
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ACCESS
  } bridge_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_to_apb_bridge_if.sv
// rtl/ahb_to_apb_bridge_if.sv - AHB-Lite and APB port bundles for the bridge
interface ahb_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HRESP;
  logic                  HREADY_OUT;

  modport master (output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
                  input  HRDATA, HRESP, HREADY_OUT);
  modport slave  (input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
                  output HRDATA, HRESP, HREADY_OUT);
endinterface

interface apb_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA);
endinterface

// File: rtl/ahb_to_apb_bridge.sv
// rtl/ahb_to_apb_bridge.sv - AHB-Lite to zero-wait APB bridge; assertions under AHB_APB_BRIDGE_SVA_EN
module ahb_to_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_interface.slave   ahb,
  apb_interface.master  apb
);

  bridge_state_t         state;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic                  hready_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic                  accept;

  assign accept = ahb.HSEL && hready_q &&
                  (htrans_t'(ahb.HTRANS) == TRANS_NONSEQ || htrans_t'(ahb.HTRANS) == TRANS_SEQ);

  // HRESETn is active-high in this codebase despite its name
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state     <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      hready_q  <= 1'b1;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            paddr_q  <= ahb.HADDR;
            pwrite_q <= ahb.HWRITE;
            hready_q <= 1'b0;
            if (ahb.HWRITE) begin
              state <= ST_WWAIT;
            end else begin
              state  <= ST_SETUP;
              psel_q <= 1'b1;
            end
          end
        end
        // Write data only becomes valid in the AHB data phase, one cycle after the address
        ST_WWAIT: begin
          pwdata_q <= ahb.HWDATA;
          psel_q   <= 1'b1;
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          hready_q  <= 1'b1;
          state     <= ST_IDLE;
          if (!pwrite_q) hrdata_q <= apb.PRDATA;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ahb.HRDATA     = hrdata_q;
  assign ahb.HRESP      = HRESP_OKAY;
  assign ahb.HREADY_OUT = hready_q;
  assign apb.PSEL       = psel_q;
  assign apb.PENABLE    = penable_q;
  assign apb.PWRITE     = pwrite_q;
  assign apb.PADDR      = paddr_q;
  assign apb.PWDATA     = pwdata_q;

`ifdef AHB_APB_BRIDGE_SVA_EN
  a_penable_after_setup: assert property (@(posedge HCLK) disable iff (HRESETn)
    $rose(penable_q) |-> $past(psel_q, 1) && !$past(psel_q, 2) && !$past(penable_q, 1));

  a_apb_stable: assert property (@(posedge HCLK) disable iff (HRESETn)
    psel_q && $past(psel_q) |-> $stable(paddr_q) && $stable(pwrite_q) && $stable(pwdata_q));

  a_penable_one_cycle: assert property (@(posedge HCLK) disable iff (HRESETn)
    penable_q |=> !penable_q);

  a_hresp_okay: assert property (@(posedge HCLK) disable iff (HRESETn)
    ahb.HRESP == HRESP_OKAY);

  a_psel_needs_accept: assert property (@(posedge HCLK) disable iff (HRESETn)
    $rose(psel_q) |-> $past(accept && !ahb.HWRITE) || $past(state == ST_WWAIT));
`endif

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// tb/tb_ahb_to_apb_bridge.sv - self-checking bench for ahb_to_apb_bridge
module tb_ahb_to_apb_bridge;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
  } vec_t;

  logic HCLK;
  logic HRESETn;

  ahb_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ahb ();
  apb_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  ahb_to_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (ahb.slave),
    .apb     (apb.master)
  );

  int   tests = 0;
  int   fails = 0;
  int   n_setup = 0;
  int   n_access = 0;
  int   exp_access = 0;
  bit   prev_setup = 0;
  vec_t apb_q[$];
  vec_t pipe_q[$];
  vec_t tbl[10];
  logic [31:0] mem [0:63];

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Zero-wait APB slave
  assign apb.PRDATA = mem[apb.PADDR[7:2]];
  always @(posedge HCLK)
    if (apb.PSEL && apb.PENABLE && apb.PWRITE) mem[apb.PADDR[7:2]] <= apb.PWDATA;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every APB phase must match the oldest outstanding AHB transfer
  always @(negedge HCLK) begin
    if (HRESETn) begin
      prev_setup = 0;
    end else if (apb.PSEL && !apb.PENABLE) begin
      n_setup++;
      if (apb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL psel_no_xfer: got PSEL=1 expected no APB activity");
      end else begin
        check("setup_paddr", apb.PADDR, apb_q[0].addr);
        check("setup_pwrite", {31'd0, apb.PWRITE}, {31'd0, apb_q[0].wr});
      end
      prev_setup = 1;
    end else if (apb.PSEL && apb.PENABLE) begin
      vec_t e;
      n_access++;
      check("access_after_setup", {31'd0, prev_setup}, 32'd1);
      check("hresp", {31'd0, ahb.HRESP}, 32'd0);
      if (apb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL access_no_xfer: got PENABLE=1 expected no APB activity");
      end else begin
        e = apb_q.pop_front();
        check("access_paddr", apb.PADDR, e.addr);
        check("access_pwrite", {31'd0, apb.PWRITE}, {31'd0, e.wr});
        if (e.wr) check("pwdata", apb.PWDATA, e.data);
        else      check("prdata", apb.PRDATA, e.data);
      end
      prev_setup = 0;
    end else begin
      prev_setup = 0;
    end
  end

  task automatic drive_addr(input vec_t v, input logic [1:0] trans);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = trans;
    ahb.HADDR  = v.addr;
    ahb.HWRITE = v.wr;
    apb_q.push_back(v);
  endtask

  task automatic drive_idle();
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
  endtask

  // Issues pipe_q back to back; next address is held through the wait states
  task automatic run_pipe();
    int n;
    int low;
    n = pipe_q.size();
    drive_addr(pipe_q[0], 2'b10);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK); #1;
      if (pipe_q[i].wr) ahb.HWDATA = pipe_q[i].data;
      if (i + 1 < n) drive_addr(pipe_q[i+1], 2'b11);
      else           drive_idle();
      low = 0;
      while (ahb.HREADY_OUT !== 1'b1 && low < 20) begin
        @(posedge HCLK); #1;
        low++;
      end
      check($sformatf("waits[%0d]", i), low, pipe_q[i].waits);
      if (!pipe_q[i].wr) check($sformatf("hrdata[%0d]", i), ahb.HRDATA, pipe_q[i].data);
      exp_access++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_psel"},    {31'd0, apb.PSEL},       32'd0);
    check({tag, "_penable"}, {31'd0, apb.PENABLE},    32'd0);
    check({tag, "_pwrite"},  {31'd0, apb.PWRITE},     32'd0);
    check({tag, "_paddr"},   apb.PADDR,               32'd0);
    check({tag, "_pwdata"},  apb.PWDATA,              32'd0);
    check({tag, "_hrdata"},  ahb.HRDATA,              32'd0);
    check({tag, "_hready"},  {31'd0, ahb.HREADY_OUT}, 32'd1);
    check({tag, "_hresp"},   {31'd0, ahb.HRESP},      32'd0);
  endtask

  function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.waits = wr ? 3 : 2;
    return v;
  endfunction

  initial begin
    int k;
    logic [1:0]  idle_trans [3];
    logic        idle_sel   [3];

    tbl[0] = mk(1, 32'h04, 32'hBEEF_BEEF);
    tbl[1] = mk(0, 32'h04, 32'hBEEF_BEEF);
    for (int i = 0; i < 4; i++) begin
      tbl[2+i] = mk(1, 32'h20 + 4*i, 32'h1000_0000 + i);
      tbl[6+i] = mk(0, 32'h20 + 4*i, 32'h1000_0000 + i);
    end
    idle_sel[0] = 1'b0; idle_trans[0] = 2'b00;
    idle_sel[1] = 1'b1; idle_trans[1] = 2'b01;
    idle_sel[2] = 1'b0; idle_trans[2] = 2'b10;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    HRESETn    = 1'b1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = 32'h0;
    ahb.HWDATA = 32'h0;

    repeat (2) @(posedge HCLK);
    #1;
    check_reset_vals("reset");
    HRESETn = 1'b0;
    @(posedge HCLK); #1;

    for (int i = 0; i < 10; i++) begin
      pipe_q.delete();
      pipe_q.push_back(tbl[i]);
      run_pipe();
    end

    // Ignored transfers: HSEL low, BUSY, and NONSEQ without HSEL
    for (int p = 0; p < 3; p++) begin
      ahb.HSEL   = idle_sel[p];
      ahb.HTRANS = idle_trans[p];
      ahb.HWRITE = 1'b1;
      ahb.HADDR  = 32'h40;
      for (int c = 0; c < 2; c++) begin
        @(posedge HCLK); #1;
        check($sformatf("ign%0d_psel", p), {31'd0, apb.PSEL}, 32'd0);
        check($sformatf("ign%0d_penable", p), {31'd0, apb.PENABLE}, 32'd0);
        check($sformatf("ign%0d_hready", p), {31'd0, ahb.HREADY_OUT}, 32'd1);
      end
    end
    drive_idle();
    ahb.HWRITE = 1'b0;

    pipe_q.delete();
    pipe_q.push_back(mk(1, 32'h10, 32'h0000_1234));
    pipe_q.push_back(mk(1, 32'h14, 32'h0000_4321));
    run_pipe();

    pipe_q.delete();
    pipe_q.push_back(mk(1, 32'h18, 32'h1234_5678));
    pipe_q.push_back(mk(0, 32'h18, 32'h1234_5678));
    run_pipe();

    pipe_q.delete();
    pipe_q.push_back(mk(0, 32'h04, 32'hBEEF_BEEF));
    pipe_q.push_back(mk(1, 32'h1C, 32'hC0FF_EE00));
    pipe_q.push_back(mk(0, 32'h1C, 32'hC0FF_EE00));
    pipe_q.push_back(mk(0, 32'h10, 32'h0000_1234));
    pipe_q.push_back(mk(0, 32'h14, 32'h0000_4321));
    run_pipe();

    // Reset asserted in ACCESS of a read: everything drops at once, no completion
    drive_addr(mk(0, 32'h18, 32'h1234_5678), 2'b10);
    @(posedge HCLK); #1;
    drive_idle();
    k = 0;
    while (!(apb.PSEL && apb.PENABLE) && k < 10) begin
      @(posedge HCLK); #1;
      k++;
    end
    check("reached_access", {31'd0, apb.PSEL && apb.PENABLE}, 32'd1);
    HRESETn = 1'b1;
    #1;
    check_reset_vals("midreset");
    apb_q.delete();
    @(posedge HCLK); #1;
    check_reset_vals("held_reset");
    HRESETn = 1'b0;
    @(posedge HCLK); #1;

    pipe_q.delete();
    pipe_q.push_back(mk(0, 32'h1C, 32'hC0FF_EE00));
    run_pipe();

    repeat (2) @(posedge HCLK);
    #1;
    check("access_count", n_access, exp_access);
    check("setup_count", n_setup, exp_access + 1);
    check("queue_drained", apb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
